// File: rtl/ft64_pti_pkg.sv
// Shared definitions for the PTI host frame loader.
// Register map, command codes and state encodings.
package ft64_pti_pkg;

  localparam logic [3:0] REG_DATA = 4'd0;
  localparam logic [3:0] REG_CTL  = 4'd1;
  localparam logic [3:0] REG_SNAP = 4'd2;
  localparam logic [3:0] REG_RXST = 4'd3;
  localparam logic [3:0] REG_TXST = 4'd5;
  localparam logic [3:0] REG_POP  = 4'd6;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;

  typedef enum logic [3:0] {
    S_INIT_CTL,
    S_INIT_WAIT,
    S_IDLE,
    S_CMD,
    S_HDR,
    S_WGET,
    S_MWR,
    S_MRD,
    S_RPUT,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    B_IDLE,
    B_CTL,
    B_SNAP,
    B_STAT,
    B_POP,
    B_DATA,
    B_PUT
  } bstate_e;

  function automatic logic [3:0] lane_sel(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/ft64_pti_byteio.sv
// PTI register-port master: FIFO reset, byte get and byte put.
// done_o is combinational on the final ack so the caller can react at once.
module ft64_pti_byteio
  import ft64_pti_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ctl_req_i,
  input  logic       get_req_i,
  input  logic       put_req_i,
  input  logic [7:0] put_dat_i,
  output logic       done_o,
  output logic [7:0] get_dat_o,
  output logic       pti_cyc_o,
  output logic       pti_stb_o,
  output logic       pti_we_o,
  output logic [3:0] pti_adr_o,
  output logic [7:0] pti_dat_o,
  input  logic       pti_ack_i,
  input  logic [7:0] pti_dat_i
);

  bstate_e    st_q;
  logic       cyc_q;
  logic       we_q;
  logic       put_q;
  logic [3:0] adr_q;
  logic [7:0] wdat_q;
  logic [7:0] pdat_q;
  logic       ack;

  assign ack       = cyc_q & pti_ack_i;
  assign pti_cyc_o = cyc_q;
  assign pti_stb_o = cyc_q;
  assign pti_we_o  = we_q;
  assign pti_adr_o = adr_q;
  assign pti_dat_o = wdat_q;
  assign get_dat_o = pti_dat_i;
  assign done_o    = ack & ((st_q == B_CTL) |
                            (st_q == B_DATA) |
                            (st_q == B_PUT));

  // Each access state issues once while cyc is low, then leaves on ack,
  // which guarantees one idle cycle between PTI accesses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= B_IDLE;
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      put_q  <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
      pdat_q <= '0;
    end else begin
      if (ack) cyc_q <= 1'b0;
      unique case (st_q)
        B_IDLE: begin
          if (ctl_req_i) begin
            st_q <= B_CTL;
          end else if (get_req_i) begin
            st_q  <= B_SNAP;
            put_q <= 1'b0;
          end else if (put_req_i) begin
            st_q   <= B_SNAP;
            put_q  <= 1'b1;
            pdat_q <= put_dat_i;
          end
        end
        B_CTL: begin
          if (!cyc_q) begin
            cyc_q  <= 1'b1;
            we_q   <= 1'b1;
            adr_q  <= REG_CTL;
            wdat_q <= 8'h00;
          end else if (pti_ack_i) begin
            st_q <= B_IDLE;
          end
        end
        B_SNAP: begin
          if (!cyc_q) begin
            cyc_q  <= 1'b1;
            we_q   <= 1'b1;
            adr_q  <= REG_SNAP;
            wdat_q <= 8'h00;
          end else if (pti_ack_i) begin
            st_q <= B_STAT;
          end
        end
        B_STAT: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= put_q ? REG_TXST : REG_RXST;
          end else if (pti_ack_i) begin
            if (pti_dat_i[7]) st_q <= B_SNAP;
            else if (put_q)   st_q <= B_PUT;
            else              st_q <= B_POP;
          end
        end
        B_POP: begin
          if (!cyc_q) begin
            cyc_q  <= 1'b1;
            we_q   <= 1'b1;
            adr_q  <= REG_POP;
            wdat_q <= 8'h00;
          end else if (pti_ack_i) begin
            st_q <= B_DATA;
          end
        end
        B_DATA: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= 1'b0;
            adr_q <= REG_DATA;
          end else if (pti_ack_i) begin
            st_q <= B_IDLE;
          end
        end
        B_PUT: begin
          if (!cyc_q) begin
            cyc_q  <= 1'b1;
            we_q   <= 1'b1;
            adr_q  <= REG_DATA;
            wdat_q <= pdat_q;
          end else if (pti_ack_i) begin
            st_q <= B_IDLE;
          end
        end
        default: st_q <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ft64_pti_loader.sv
// Host frame engine: parses W/R frames from the PTI and drives
// byte writes/reads on the 32-bit memory master, answering ACK/NAK.
module ft64_pti_loader
  import ft64_pti_pkg::*;
#(
  parameter int unsigned INIT_WAIT = 16,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic        busy_o,
  output logic        nak_o,
  output logic        pti_cs_o,
  output logic        pti_cyc_o,
  output logic        pti_stb_o,
  output logic        pti_we_o,
  output logic [3:0]  pti_adr_o,
  output logic [7:0]  pti_dat_o,
  input  logic        pti_ack_i,
  input  logic [7:0]  pti_dat_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i
);

  localparam logic [15:0] WAIT_LAST = 16'(INIT_WAIT - 1);

  state_e      st_q;
  logic [15:0] wcnt_q;
  logic [7:0]  cmd_q;
  logic [7:0]  rbyte_q;
  logic [31:0] adr_q;
  logic [15:0] len_q;
  logic [2:0]  hcnt_q;
  logic        nakf_q;
  logic        busy_q;
  logic        nak_q;
  logic        m_cyc_q;
  logic        m_we_q;
  logic [3:0]  m_sel_q;
  logic [31:0] m_adr_q;
  logic [31:0] m_dat_q;

  logic        ctl_req;
  logic        get_req;
  logic        put_req;
  logic [7:0]  put_dat;
  logic        bio_done;
  logic [7:0]  bio_dat;
  logic        pti_cyc;
  logic        m_ack;
  logic [7:0]  lane_byte;

  assign ctl_req = (st_q == S_INIT_CTL);
  assign get_req = (st_q == S_CMD) | (st_q == S_HDR) | (st_q == S_WGET);
  assign put_req = (st_q == S_RPUT) | (st_q == S_RESP);
  assign put_dat = (st_q == S_RPUT) ? rbyte_q :
                   (nakf_q ? NAK_BYTE : ACK_BYTE);

  assign m_ack     = m_cyc_q & m_ack_i;
  assign lane_byte = m_dat_i[{m_adr_q[1:0], 3'b000} +: 8];

  assign busy_o    = busy_q;
  assign nak_o     = nak_q;
  assign pti_cs_o  = pti_cyc;
  assign pti_cyc_o = pti_cyc;
  assign m_cyc_o   = m_cyc_q;
  assign m_stb_o   = m_cyc_q;
  assign m_we_o    = m_we_q;
  assign m_sel_o   = m_sel_q;
  assign m_adr_o   = m_adr_q;
  assign m_dat_o   = m_dat_q;

  ft64_pti_byteio u_bio (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ctl_req_i (ctl_req),
    .get_req_i (get_req),
    .put_req_i (put_req),
    .put_dat_i (put_dat),
    .done_o    (bio_done),
    .get_dat_o (bio_dat),
    .pti_cyc_o (pti_cyc),
    .pti_stb_o (pti_stb_o),
    .pti_we_o  (pti_we_o),
    .pti_adr_o (pti_adr_o),
    .pti_dat_o (pti_dat_o),
    .pti_ack_i (pti_ack_i),
    .pti_dat_i (pti_dat_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= S_INIT_CTL;
      wcnt_q  <= '0;
      cmd_q   <= '0;
      rbyte_q <= '0;
      adr_q   <= '0;
      len_q   <= '0;
      hcnt_q  <= '0;
      nakf_q  <= 1'b0;
      busy_q  <= 1'b0;
      nak_q   <= 1'b0;
      m_cyc_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_sel_q <= '0;
      m_adr_q <= '0;
      m_dat_q <= '0;
    end else begin
      nak_q <= 1'b0;
      if (m_ack) m_cyc_q <= 1'b0;
      unique case (st_q)
        S_INIT_CTL: begin
          if (bio_done) begin
            st_q   <= S_INIT_WAIT;
            wcnt_q <= '0;
          end
        end
        S_INIT_WAIT: begin
          if (wcnt_q == WAIT_LAST) st_q <= S_IDLE;
          else wcnt_q <= wcnt_q + 16'd1;
        end
        S_IDLE: begin
          nakf_q <= 1'b0;
          if (en_i) st_q <= S_CMD;
        end
        S_CMD: begin
          if (bio_done) begin
            busy_q <= 1'b1;
            cmd_q  <= bio_dat;
            hcnt_q <= '0;
            if (bio_dat == CMD_W || bio_dat == CMD_R) begin
              st_q <= S_HDR;
            end else begin
              nakf_q <= 1'b1;
              st_q   <= S_RESP;
            end
          end
        end
        S_HDR: begin
          if (bio_done) begin
            hcnt_q <= hcnt_q + 3'd1;
            if (!hcnt_q[2]) begin
              adr_q[{hcnt_q[1:0], 3'b000} +: 8] <= bio_dat;
            end else if (hcnt_q == 3'd4) begin
              len_q[7:0] <= bio_dat;
            end else begin
              len_q[15:8] <= bio_dat;
              if ({bio_dat, len_q[7:0]} == 16'd0) begin
                st_q <= S_RESP;
              end else if (cmd_q == CMD_W) begin
                st_q <= S_WGET;
              end else begin
                st_q    <= S_MRD;
                m_cyc_q <= 1'b1;
                m_we_q  <= 1'b0;
                m_adr_q <= adr_q;
                m_sel_q <= lane_sel(adr_q[1:0]);
                m_dat_q <= '0;
              end
            end
          end
        end
        S_WGET: begin
          if (bio_done) begin
            st_q    <= S_MWR;
            m_cyc_q <= 1'b1;
            m_we_q  <= 1'b1;
            m_adr_q <= adr_q;
            m_sel_q <= lane_sel(adr_q[1:0]);
            m_dat_q <= {4{bio_dat}};
          end
        end
        S_MWR: begin
          if (m_ack) begin
            adr_q <= adr_q + 32'd1;
            len_q <= len_q - 16'd1;
            st_q  <= (len_q == 16'd1) ? S_RESP : S_WGET;
          end
        end
        S_MRD: begin
          if (m_ack) begin
            rbyte_q <= lane_byte;
            adr_q   <= adr_q + 32'd1;
            len_q   <= len_q - 16'd1;
            st_q    <= S_RPUT;
          end
        end
        S_RPUT: begin
          if (bio_done) begin
            if (len_q == 16'd0) begin
              st_q <= S_RESP;
            end else begin
              st_q    <= S_MRD;
              m_cyc_q <= 1'b1;
              m_we_q  <= 1'b0;
              m_adr_q <= adr_q;
              m_sel_q <= lane_sel(adr_q[1:0]);
              m_dat_q <= '0;
            end
          end
        end
        S_RESP: begin
          if (bio_done) begin
            busy_q <= 1'b0;
            nak_q  <= nakf_q;
            st_q   <= S_IDLE;
          end
        end
        default: st_q <= S_INIT_CTL;
      endcase
    end
  end

endmodule

// File: tb/tb_ft64_pti_loader.sv
// Bench for ft64_pti_loader: PTI and memory responders feed
// scoreboard monitors that compare against queued expectations.
module tb_ft64_pti_loader;

  localparam int INIT_WAIT = 16;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        busy_o, nak_o;
  logic        pti_cs, pti_cyc, pti_stb, pti_we;
  logic [3:0]  pti_adr;
  logic [7:0]  pti_wdat;
  logic        pti_ack = 1'b0;
  logic [7:0]  pti_rdat = 8'h00;
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_wdat;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdat = 32'h0;

  ft64_pti_loader #(
    .INIT_WAIT (INIT_WAIT),
    .ACK_BYTE  (8'h06),
    .NAK_BYTE  (8'h15)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .busy_o    (busy_o),
    .nak_o     (nak_o),
    .pti_cs_o  (pti_cs),
    .pti_cyc_o (pti_cyc),
    .pti_stb_o (pti_stb),
    .pti_we_o  (pti_we),
    .pti_adr_o (pti_adr),
    .pti_dat_o (pti_wdat),
    .pti_ack_i (pti_ack),
    .pti_dat_i (pti_rdat),
    .m_cyc_o   (m_cyc),
    .m_stb_o   (m_stb),
    .m_we_o    (m_we),
    .m_sel_o   (m_sel),
    .m_adr_o   (m_adr),
    .m_dat_o   (m_wdat),
    .m_ack_i   (m_ack),
    .m_dat_i   (m_rdat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [7:0]  rxq[$];
  logic [7:0]  exp_tx[$];
  mem_t        exp_mem[$];
  logic [31:0] rdq[$];

  int   empty_force = 0;
  int   full_force  = 0;
  int   ctl_cnt     = 0;
  int   pop_cnt     = 0;
  int   txst_reads  = 0;
  int   nak_cnt     = 0;
  int   ctl_cyc     = 0;
  logic snap_seen   = 1'b0;
  logic tx_ok       = 1'b0;
  logic resp_chk    = 1'b0;
  logic [7:0] latch = 8'h00;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PTI slave model and TX scoreboard
  always @(negedge clk) begin
    if (resp_chk) begin
      resp_chk = 1'b0;
      chk("busy_fall", {31'd0, busy_o}, 32'd0);
    end
    if (rst) begin
      pti_ack = 1'b0;
    end else if (pti_ack) begin
      pti_ack = 1'b0;
    end else if (pti_cyc && pti_stb) begin
      pti_ack = 1'b1;
      chk("pti_cs", {31'd0, pti_cs}, 32'd1);
      if (pti_we) begin
        case (pti_adr)
          4'd1: begin
            chk("ctl_dat", {24'd0, pti_wdat}, 32'h0);
            ctl_cnt++;
            ctl_cyc   = cyc_n;
            snap_seen = 1'b0;
          end
          4'd2: begin
            if (!snap_seen) begin
              snap_seen = 1'b1;
              chk("init_gap_ok", {31'd0, (cyc_n - ctl_cyc) >= INIT_WAIT},
                  32'd1);
            end
          end
          4'd6: begin
            pop_cnt++;
            if (rxq.size() != 0) latch = rxq.pop_front();
          end
          4'd0: begin
            chk("put_after_status", {31'd0, tx_ok}, 32'd1);
            tx_ok = 1'b0;
            if (exp_tx.size() == 0) begin
              chk("tx_unexpected", {24'd0, pti_wdat}, 32'hFFFF_FFFF);
            end else begin
              if (exp_tx[0] == 8'h06 || exp_tx[0] == 8'h15) resp_chk = 1'b1;
              chk("tx_byte", {24'd0, pti_wdat}, {24'd0, exp_tx.pop_front()});
            end
          end
          default: chk("pti_wr_adr", {28'd0, pti_adr}, 32'hFFFF_FFFF);
        endcase
      end else begin
        case (pti_adr)
          4'd3: begin
            pti_rdat = {(empty_force > 0) || (rxq.size() == 0), 7'd0};
            if (empty_force > 0) empty_force--;
          end
          4'd5: begin
            txst_reads++;
            pti_rdat = {full_force > 0, 7'd0};
            tx_ok    = (full_force == 0);
            if (full_force > 0) full_force--;
          end
          4'd0: pti_rdat = latch;
          default: chk("pti_rd_adr", {28'd0, pti_adr}, 32'hFFFF_FFFF);
        endcase
      end
    end
  end

  // Memory slave model and access scoreboard
  always @(negedge clk) begin
    if (rst) begin
      m_ack = 1'b0;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (m_cyc && m_stb) begin
      m_ack = 1'b1;
      if (exp_mem.size() == 0) begin
        chk("mem_unexpected", m_adr, 32'hFFFF_FFFF);
      end else begin
        mem_t e;
        e = exp_mem.pop_front();
        chk("mem_we", {31'd0, m_we}, {31'd0, e.we});
        chk("mem_adr", m_adr, e.adr);
        chk("mem_sel", {28'd0, m_sel}, {28'd0, e.sel});
        if (e.we) chk("mem_dat", m_wdat, e.dat);
      end
      if (!m_we) m_rdat = (rdq.size() != 0) ? rdq.pop_front() : 32'h0;
    end
  end

  always @(negedge clk) if (nak_o) nak_cnt++;

  task automatic exp_w(input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    mem_t e;
    e.we = 1'b1; e.adr = a; e.sel = s; e.dat = d;
    exp_mem.push_back(e);
  endtask

  task automatic exp_r(input logic [31:0] a, input logic [3:0] s);
    mem_t e;
    e.we = 1'b0; e.adr = a; e.sel = s; e.dat = 32'h0;
    exp_mem.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_mem.size() != 0 ||
            rxq.size() != 0 || busy_o) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s: timeout, tx left %0d mem left %0d", name,
               exp_tx.size(), exp_mem.size());
    end
  endtask

  initial begin
    int n;
    int p0;
    int c0;
    // 1: reset values and init sequence
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_nak", {31'd0, nak_o}, 32'd0);
    chk("rst_pti_cyc", {31'd0, pti_cyc}, 32'd0);
    chk("rst_pti_adr", {28'd0, pti_adr}, 32'd0);
    chk("rst_m_cyc", {31'd0, m_cyc}, 32'd0);
    chk("rst_m_sel", {28'd0, m_sel}, 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    n = 0;
    while (!snap_seen && n < 500) begin @(negedge clk); n++; end
    chk("init_ctl_cnt", ctl_cnt, 32'd1);
    chk("init_snap_seen", {31'd0, snap_seen}, 32'd1);

    // 2: W frame with empty polls first
    empty_force = 3;
    exp_w(32'h0000_1003, 4'b1000, 32'hAAAA_AAAA);
    exp_w(32'h0000_1004, 4'b0001, 32'hBBBB_BBBB);
    exp_w(32'h0000_1005, 4'b0010, 32'hCCCC_CCCC);
    exp_tx.push_back(8'h06);
    rxq = {rxq, 8'h57, 8'h03, 8'h10, 8'h00, 8'h00, 8'h03, 8'h00,
           8'hAA, 8'hBB, 8'hCC};
    drain("w_frame");

    // 3: R frame wrapping the address
    rdq = {rdq, 32'h1122_3344, 32'h5566_7788};
    exp_r(32'hFFFF_FFFF, 4'b1000);
    exp_r(32'h0000_0000, 4'b0001);
    exp_tx = {exp_tx, 8'h11, 8'h88, 8'h06};
    rxq = {rxq, 8'h52, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00};
    drain("r_wrap");

    // 4: unknown command, then a normal W frame
    exp_tx.push_back(8'h15);
    rxq.push_back(8'h3F);
    drain("nak");
    chk("nak_pulses", nak_cnt, 32'd1);
    exp_w(32'h0000_0000, 4'b0001, 32'h5A5A_5A5A);
    exp_tx.push_back(8'h06);
    rxq = {rxq, 8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h5A};
    drain("w_after_nak");

    // zero length: header then ACK, no memory access
    exp_tx.push_back(8'h06);
    rxq = {rxq, 8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    drain("len_zero");

    // 5: TX full backpressure during R response
    full_force = 5;
    txst_reads = 0;
    rdq.push_back(32'hAABB_CCDD);
    exp_r(32'h0000_2000, 4'b0001);
    exp_tx = {exp_tx, 8'hDD, 8'h06};
    rxq = {rxq, 8'h52, 8'h00, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00};
    drain("tx_full");
    chk("txst_reads", txst_reads, 32'd7);
    chk("nak_pulses_end", nak_cnt, 32'd1);

    // 6: reset mid-payload
    exp_w(32'h0000_0010, 4'b0001, 32'h0101_0101);
    p0 = pop_cnt;
    rxq = {rxq, 8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00,
           8'h01, 8'h02, 8'h03};
    n = 0;
    while (pop_cnt < p0 + 9 && n < 5000) begin @(negedge clk); n++; end
    chk("mid_pop_reached", {31'd0, pop_cnt >= p0 + 9}, 32'd1);
    chk("mid_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    c0  = ctl_cnt;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_pti_cyc", {31'd0, pti_cyc}, 32'd0);
    chk("mid_rst_m_cyc", {31'd0, m_cyc}, 32'd0);
    rxq.delete();
    rst = 1'b0;
    n = 0;
    while (ctl_cnt == c0 && n < 500) begin @(negedge clk); n++; end
    chk("reinit_ctl", ctl_cnt, c0 + 1);
    repeat (200) @(negedge clk);
    chk("mid_mem_left", exp_mem.size(), 32'd0);
    chk("mid_tx_left", exp_tx.size(), 32'd0);
    chk("mid_busy_idle", {31'd0, busy_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft64_pti_loader.md
Name: ft64_pti_loader

Overview:
Host-side frame engine downstream of the parallel transfer interface (PTI) Wishbone slave. Acts as Wishbone master on the PTI register port: pulls received bytes, parses host command frames, then performs byte writes/reads on a 32-bit system memory master port. Returns read data and ACK/NAK bytes to the host through the PTI transmit FIFO. Used for program download and memory dump over USB without CPU involvement.

Parameters:
INIT_WAIT, 16, cycles to idle after the PTI control-register write before the first poll (must be 8 or more)
ACK_BYTE, 8'h06, response byte on successful frame
NAK_BYTE, 8'h15, response byte on unknown command

Ports:
clk_i  in  1  system clock, also drives the PTI Wishbone side
rst_i  in  1  synchronous active-high reset
en_i  in  1  enable; 0 holds the engine in IDLE between frames
busy_o  out  1  high from first command byte until the response byte is acknowledged
nak_o  out  1  one-cycle pulse when NAK is sent
pti_cs_o  out  1  PTI chip select, equal to pti_cyc_o
pti_cyc_o  out  1  PTI bus cycle
pti_stb_o  out  1  PTI strobe
pti_we_o  out  1  PTI write enable
pti_adr_o  out  4  PTI register address
pti_dat_o  out  8  PTI write data
pti_ack_i  in  1  PTI acknowledge
pti_dat_i  in  8  PTI read data
m_cyc_o  out  1  memory bus cycle
m_stb_o  out  1  memory strobe
m_we_o  out  1  memory write enable
m_sel_o  out  4  memory byte lanes
m_adr_o  out  32  memory byte address
m_dat_o  out  32  memory write data, byte replicated on all lanes
m_ack_i  in  1  memory acknowledge
m_dat_i  in  32  memory read data

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: all outputs 0. State is INIT_CTL, address 0, length 0.
- Bus rules, both ports:
  - cyc and stb assert together and hold until ack.
  - On the ack cycle, latch read data and drop cyc/stb the next cycle.
  - At least 1 idle cycle between PTI accesses, because the PTI clears its one-shot flags on cyc low.
  - There is no bus timeout.
- PTI register use:
  - Write reg1 = 8'h00: reset FIFOs and disable loopback.
  - Write reg2 = any value: snapshot status.
  - Read reg3 bit7: RX empty.
  - Read reg5 bit7: TX full.
  - Write reg6: pop RX FIFO into the latch.
  - Read reg0: latched RX byte.
  - Write reg0: TX byte.
- Init sequence: INIT_CTL does the reg1 write, then INIT_WAIT counts INIT_WAIT cycles, then IDLE.
- GETB sequence: SNAP (wr reg2) -> STAT (rd reg3). If bit7=1, go back to SNAP; otherwise POP (wr reg6) -> DATA (rd reg0) -> return to caller with the byte.
- PUTB sequence: SNAP (wr reg2) -> STAT (rd reg5). If bit7=1, go back to SNAP; otherwise PUT (wr reg0) -> return to caller.
- Frame format, little-endian: cmd, addr[7:0..31:24], len[7:0], len[15:8], then payload.
- IDLE: when en_i=1, GETB the command byte and set busy_o.
- cmd 8'h57 'W':
  - Collect 4 address bytes and 2 length bytes.
  - Then repeat len times: GETB, then memory write with m_sel_o = 4'b0001<<adr[1:0], m_dat_o = {4{byte}}, then addr+1.
  - Then PUTB ACK_BYTE.
- cmd 8'h52 'R':
  - Collect address and length as for W.
  - Then repeat len times: memory read with the same m_sel_o, then PUTB m_dat_i lane adr[1:0], then addr+1.
  - Then PUTB ACK_BYTE.
- Any other cmd: PUTB NAK_BYTE, pulse nak_o, return to IDLE. Following bytes are parsed as new commands.
- len=0: no memory access; ACK is sent immediately after the header.
- Address arithmetic: 32-bit and wraps FFFF_FFFF -> 0000_0000.
- Length counter: 16-bit down-counter, so the maximum payload is 65535 bytes.
- busy_o deasserts the cycle after the ack of the response PUT. The engine returns to IDLE.
- rst_i mid-frame: abort immediately, drop cyc, return to INIT_CTL, re-run the FIFO reset. A partial frame is lost.

Decomposition:
- Shared package ft64_pti_pkg holds:
  - PTI register offsets REG_DATA=0, REG_CTL=1, REG_SNAP=2, REG_RXST=3, REG_TXST=5, REG_POP=6;
  - command codes CMD_W, CMD_R;
  - the state enumeration.
- One sub-module, ft64_pti_byteio, owns the PTI master port and the GETB/PUTB sequences. Its interface is get_req / put_req / put_dat in and done / get_dat out. The top holds the frame FSM, counters and memory master.

Test Plan:
1. Reset then run -> PTI writes reg1=00. The first reg2 snapshot occurs no earlier than INIT_WAIT cycles later.
2. RX empty for 3 polls, then host sends 57 03 10 00 00 03 00 AA BB CC ->
   - memory writes adr 1003 sel 1000 dat AAAAAAAA;
   - adr 1004 sel 0001 dat BBBBBBBB;
   - adr 1005 sel 0010 dat CCCCCCCC;
   - then TX 06 and busy_o falls.
3. Host sends 52 FF FF FF FF 02 00, memory returns 11223344 then 55667788 -> reads at FFFFFFFF (sel 1000), then 00000000 (sel 0001). TX bytes are 11, 88, 06.
4. Host sends 3F -> TX 15, one nak_o pulse, no memory cycle, back to IDLE. A following W frame is handled normally.
5. TX full for 5 polls during the R response -> the PUT to reg0 occurs only after reg5 bit7=0. Exactly 1 write per byte.
6. rst_i asserted during W payload byte 2 -> outputs clear the next cycle, a new reg1=00 write occurs, and no further memory writes happen.
